// File: rtl/reset_release_seq.sv
// Sequenced reset release: synchronizes the incoming reset, holds all stages,
// then releases them one by one, each gated on the previous stage's ready.
module reset_release_seq #(
   parameter int N_STAGES    = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int ACK_TIMEOUT = 1024,
   parameter int CNT_W       = 16
) (
   input  logic                clk_in,
   input  logic                reset_in_n,
   input  logic                sw_reset_req,
   input  logic [N_STAGES-1:0] stage_ready,
   output logic [N_STAGES-1:0] stage_reset_n,
   output logic                all_ready,
   output logic                busy,
   output logic                timeout_err,
   output logic [2:0]          cur_stage
);

   localparam int MAX_CNT =
      (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

   generate
      if ((64'd1 << CNT_W) <= 64'(MAX_CNT)) begin : g_cnt_chk
         $error("CNT_W too narrow for HOLD_CYCLES/ACK_TIMEOUT");
      end
      if (N_STAGES < 1 || N_STAGES > 8) begin : g_stg_chk
         $error("N_STAGES must be 1..8");
      end
      if (HOLD_CYCLES < 1 || ACK_TIMEOUT < 2) begin : g_par_chk
         $error("HOLD_CYCLES must be >=1, ACK_TIMEOUT >=2");
      end
   endgenerate

   typedef enum logic [1:0] {
      SYNC,
      HOLD,
      WAIT,
      DONE
   } state_t;

   state_t              state, state_nx;
   logic [1:0]          sync_q;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic [2:0]          idx, idx_nx;
   logic [N_STAGES-1:0] rst_nx;
   logic [N_STAGES-1:0] sel;
   logic                all_nx;
   logic                err_nx;
   logic                hit;
   logic                last;

   always_ff @(posedge clk_in or negedge reset_in_n) begin
      if (!reset_in_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   always_ff @(posedge clk_in or negedge reset_in_n) begin
      if (!reset_in_n) begin
         state         <= SYNC;
         cnt           <= '0;
         idx           <= 3'd0;
         stage_reset_n <= '0;
         all_ready     <= 1'b0;
         timeout_err   <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         idx           <= idx_nx;
         stage_reset_n <= rst_nx;
         all_ready     <= all_nx;
         timeout_err   <= err_nx;
      end
   end

   always_comb begin
      sel = '0;
      for (int j = 0; j < N_STAGES; j++) begin
         if (3'(j) == idx) sel[j] = 1'b1;
      end
   end

   assign hit  = |(stage_ready & sel);
   assign last = sel[N_STAGES-1];

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      idx_nx   = idx;
      rst_nx   = stage_reset_n;
      all_nx   = all_ready;
      err_nx   = timeout_err;
      unique case (state)
         // sync_q[0] is what the second flop loads on this edge
         SYNC: begin
            if (sync_q[0]) begin
               state_nx = HOLD;
               cnt_nx   = '0;
            end
         end
         HOLD: begin
            if (sync_q[1]) begin
               if (cnt == HOLD_LAST) begin
                  rst_nx[0] = 1'b1;
                  cnt_nx    = '0;
                  idx_nx    = 3'd0;
                  state_nx  = WAIT;
               end else begin
                  cnt_nx = cnt + CNT_W'(1);
               end
            end
         end
         WAIT: begin
            if (hit || cnt == ACK_LAST) begin
               err_nx = timeout_err | ~hit;
               cnt_nx = '0;
               if (last) begin
                  state_nx = DONE;
                  all_nx   = &stage_ready;
               end else begin
                  idx_nx = idx + 3'd1;
                  rst_nx = stage_reset_n | (sel << 1);
               end
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         DONE: begin
            all_nx = &stage_ready;
         end
         default: state_nx = SYNC;
      endcase
      // restart beats any ready or timeout seen on the same edge
      if (state != SYNC && sw_reset_req) begin
         state_nx = HOLD;
         cnt_nx   = '0;
         idx_nx   = 3'd0;
         rst_nx   = '0;
         all_nx   = 1'b0;
      end
   end

   always_comb begin
      busy      = (state != DONE);
      cur_stage = idx;
   end

endmodule

// File: tb/tb_reset_release_seq.sv
// Directed bench for reset_release_seq (N=4, HOLD=16, ACK_TIMEOUT=64).
// Samples 1ns after each rising edge; inputs change at the same point.
module tb_reset_release_seq;

   logic       clk_in = 1'b0;
   logic       reset_in_n;
   logic       sw_reset_req;
   logic [3:0] stage_ready;
   logic [3:0] stage_reset_n;
   logic       all_ready;
   logic       busy;
   logic       timeout_err;
   logic [2:0] cur_stage;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   reset_release_seq #(
      .N_STAGES   (4),
      .HOLD_CYCLES(16),
      .ACK_TIMEOUT(64),
      .CNT_W      (16)
   ) dut (
      .clk_in       (clk_in),
      .reset_in_n   (reset_in_n),
      .sw_reset_req (sw_reset_req),
      .stage_ready  (stage_ready),
      .stage_reset_n(stage_reset_n),
      .all_ready    (all_ready),
      .busy         (busy),
      .timeout_err  (timeout_err),
      .cur_stage    (cur_stage)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic tickn(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk_rst(input string tag);
      check({tag, ".rstn"}, 32'(stage_reset_n), 32'h0);
      check({tag, ".busy"}, 32'(busy), 32'h1);
      check({tag, ".all"},  32'(all_ready), 32'h0);
      check({tag, ".err"},  32'(timeout_err), 32'h0);
      check({tag, ".cur"},  32'(cur_stage), 32'h0);
   endtask

   initial begin
      reset_in_n   = 1'b0;
      sw_reset_req = 1'b0;
      stage_ready  = 4'hF;
      tickn(3);
      chk_rst("por");

      // power-up, all ready tied high
      reset_in_n = 1'b1;
      tickn(17);
      check("p1.e17", 32'(stage_reset_n), 32'h0);
      tick();
      check("p1.e18", 32'(stage_reset_n), 32'h1);
      check("p1.e18c", 32'(cur_stage), 32'h0);
      tick();
      check("p1.e19", 32'(stage_reset_n), 32'h3);
      check("p1.e19c", 32'(cur_stage), 32'h1);
      tick();
      check("p1.e20", 32'(stage_reset_n), 32'h7);
      tick();
      check("p1.e21", 32'(stage_reset_n), 32'hF);
      check("p1.e21b", 32'(busy), 32'h1);
      tick();
      check("p1.busy", 32'(busy), 32'h0);
      check("p1.all", 32'(all_ready), 32'h1);
      check("p1.cur", 32'(cur_stage), 32'h3);
      check("p1.err", 32'(timeout_err), 32'h0);

      // slow ready[1], stuck ready[2]
      reset_in_n  = 1'b0;
      stage_ready = 4'b1001;
      #1;
      chk_rst("r2");
      tick();
      reset_in_n = 1'b1;
      tickn(18);
      check("p2.e18", 32'(stage_reset_n), 32'h1);
      tick();
      check("p2.s1", 32'(stage_reset_n), 32'h3);
      tickn(10);
      check("p2.hold1", 32'(stage_reset_n), 32'h3);
      stage_ready[1] = 1'b1;
      tick();
      check("p2.s2", 32'(stage_reset_n), 32'h7);
      check("p2.err0", 32'(timeout_err), 32'h0);
      check("p2.cur2", 32'(cur_stage), 32'h2);
      tickn(63);
      check("p2.to63", 32'(stage_reset_n), 32'h7);
      check("p2.err63", 32'(timeout_err), 32'h0);
      tick();
      check("p2.to64", 32'(stage_reset_n), 32'hF);
      check("p2.err64", 32'(timeout_err), 32'h1);
      check("p2.cur3", 32'(cur_stage), 32'h3);
      tick();
      check("p2.busy", 32'(busy), 32'h0);
      check("p2.all", 32'(all_ready), 32'h0);
      stage_ready = 4'hF;
      tick();
      check("p2.all1", 32'(all_ready), 32'h1);
      stage_ready[0] = 1'b0;
      tick();
      check("p2.drop", 32'(all_ready), 32'h0);
      check("p2.dropr", 32'(stage_reset_n), 32'hF);
      check("p2.dropb", 32'(busy), 32'h0);
      stage_ready = 4'hF;

      // software restart from DONE keeps timeout_err
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      check("sw.rstn", 32'(stage_reset_n), 32'h0);
      check("sw.busy", 32'(busy), 32'h1);
      check("sw.all", 32'(all_ready), 32'h0);
      check("sw.cur", 32'(cur_stage), 32'h0);
      check("sw.err", 32'(timeout_err), 32'h1);
      tickn(15);
      check("sw.e15", 32'(stage_reset_n), 32'h0);
      tick();
      check("sw.e16", 32'(stage_reset_n), 32'h1);
      tickn(3);
      check("sw.e19", 32'(stage_reset_n), 32'hF);
      tick();
      check("sw.all1", 32'(all_ready), 32'h1);
      check("sw.err1", 32'(timeout_err), 32'h1);

      // async reset during WAIT(1)
      stage_ready  = 4'b0001;
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      tickn(17);
      check("ar.w1", 32'(stage_reset_n), 32'h3);
      check("ar.w1c", 32'(cur_stage), 32'h1);
      tickn(2);
      reset_in_n = 1'b0;
      #1;
      chk_rst("ar");
      stage_ready = 4'hF;
      tickn(3);
      reset_in_n = 1'b1;
      tickn(17);
      check("ar.e17", 32'(stage_reset_n), 32'h0);
      tick();
      check("ar.e18", 32'(stage_reset_n), 32'h1);

      // sw restart wins over ready[0] in WAIT(0)
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      check("pr.rstn", 32'(stage_reset_n), 32'h0);
      check("pr.cur", 32'(cur_stage), 32'h0);
      check("pr.busy", 32'(busy), 32'h1);
      tickn(15);
      check("pr.e15", 32'(stage_reset_n), 32'h0);
      tick();
      check("pr.e16", 32'(stage_reset_n), 32'h1);

      // sw request ignored while in SYNC
      reset_in_n = 1'b0;
      tickn(2);
      reset_in_n   = 1'b1;
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      tickn(16);
      check("sy.e17", 32'(stage_reset_n), 32'h0);
      tick();
      check("sy.e18", 32'(stage_reset_n), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
